// File: rtl/win3x3_linebuf.sv
// 3x3 sliding window generator over a raster-order pixel stream.
// Two line buffers hold the previous two lines; a 3x3 register window
// shifts one column per accepted sample and is driven straight to the taps.
module win3x3_linebuf #(
    parameter int DW    = 10,
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] pix_in,
    input  logic          pix_valid,
    input  logic          sof,
    output logic [DW-1:0] da,
    output logic [DW-1:0] db,
    output logic [DW-1:0] dc,
    output logic [DW-1:0] dd,
    output logic [DW-1:0] de,
    output logic [DW-1:0] df,
    output logic [DW-1:0] dg,
    output logic [DW-1:0] dh,
    output logic [DW-1:0] di,
    output logic          win_valid,
    output logic          frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col_reg, col_next, eff_col;
    logic [RW-1:0] row_reg, row_next, eff_row;
    logic          win_hit;
    logic          frame_end;

    logic [DW-1:0] line1_mem [IMG_W];
    logic [DW-1:0] line2_mem [IMG_W];
    logic [DW-1:0] line1_rd_reg;
    logic [DW-1:0] line2_rd_reg;

    logic [DW-1:0]   new_col  [3];
    logic [3*DW-1:0] row_taps [3];

    logic win_valid_reg;
    logic frame_done_reg;

    // Position of the current sample and next-state of the raster counters.
    // A sof sample is always col 0 / row 0 and never ends a frame.
    always_comb begin
        eff_col   = sof ? '0 : col_reg;
        eff_row   = sof ? '0 : row_reg;
        col_next  = col_reg;
        row_next  = row_reg;
        win_hit   = 1'b0;
        frame_end = 1'b0;
        if (rst) begin
            col_next = '0;
            row_next = '0;
        end else if (pix_valid) begin
            win_hit = (eff_row >= RW'(2)) && (eff_col >= CW'(2));
            if (sof) begin
                col_next = CW'(1);
                row_next = '0;
            end else if (col_reg == COL_LAST) begin
                col_next = '0;
                if (row_reg == ROW_LAST) begin
                    row_next  = '0;
                    frame_end = 1'b1;
                end else begin
                    row_next = row_reg + RW'(1);
                end
            end else begin
                col_next = col_reg + CW'(1);
            end
        end
    end

    // Raster counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_reg        <= '0;
            row_reg        <= '0;
            win_valid_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            col_reg        <= col_next;
            row_reg        <= row_next;
            win_valid_reg  <= win_hit;
            frame_done_reg <= frame_end;
        end
    end

    // Line buffers with registered read. The read address is the column of
    // the next sample, so the data is ready when that sample arrives; it
    // never collides with the write address because IMG_W >= 3. After a
    // mid-frame sof the prefetched word is stale, but rows 0 and 1 refill
    // both lines before any window is flagged valid.
    always_ff @(posedge clk) begin
        if (pix_valid && !rst) begin
            line1_mem[eff_col] <= pix_in;
            line2_mem[eff_col] <= line1_rd_reg;
        end
        line1_rd_reg <= line1_mem[col_next];
        line2_rd_reg <= line2_mem[col_next];
    end

    // New right-hand column: top = two lines up, middle = one line up, bottom = live pixel.
    assign new_col[0] = line2_rd_reg;
    assign new_col[1] = line1_rd_reg;
    assign new_col[2] = pix_in;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : gen_row
            logic [DW-1:0] t0_reg, t1_reg, t2_reg;

            // Shift this window row left by one column on each accepted sample.
            always_ff @(posedge clk) begin
                if (rst) begin
                    t0_reg <= '0;
                    t1_reg <= '0;
                    t2_reg <= '0;
                end else if (pix_valid) begin
                    t0_reg <= t1_reg;
                    t1_reg <= t2_reg;
                    t2_reg <= new_col[gi];
                end
            end

            assign row_taps[gi] = {t0_reg, t1_reg, t2_reg};
        end
    endgenerate

    assign da = row_taps[0][3*DW-1 -: DW];
    assign db = row_taps[0][2*DW-1 -: DW];
    assign dc = row_taps[0][DW-1   -: DW];
    assign dd = row_taps[1][3*DW-1 -: DW];
    assign de = row_taps[1][2*DW-1 -: DW];
    assign df = row_taps[1][DW-1   -: DW];
    assign dg = row_taps[2][3*DW-1 -: DW];
    assign dh = row_taps[2][2*DW-1 -: DW];
    assign di = row_taps[2][DW-1   -: DW];

    assign win_valid  = win_valid_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_win3x3_linebuf.sv
// Self-checking bench for win3x3_linebuf: a 4x4 instance for directed
// scenarios and a 32x32 instance for random frames. Expected windows are
// cut directly out of the frame image held in the bench.
module tb_win3x3_linebuf;

    localparam int DW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // 4x4 instance
    logic          rst4, pv4, sof4;
    logic [DW-1:0] pix4;
    logic [DW-1:0] a4, b4, c4, d4, e4, f4, g4, h4, i4;
    logic          wv4, fd4;

    // 32x32 instance
    logic          rst32, pv32, sof32;
    logic [DW-1:0] pix32;
    logic [DW-1:0] a32, b32, c32, d32, e32, f32, g32, h32, i32;
    logic          wv32, fd32;

    int exp4  [16];
    int img32 [1024];

    win3x3_linebuf #(.DW(DW), .IMG_W(4), .IMG_H(4)) dut4 (
        .clk(clk), .rst(rst4), .pix_in(pix4), .pix_valid(pv4), .sof(sof4),
        .da(a4), .db(b4), .dc(c4), .dd(d4), .de(e4), .df(f4), .dg(g4), .dh(h4), .di(i4),
        .win_valid(wv4), .frame_done(fd4)
    );

    win3x3_linebuf #(.DW(DW), .IMG_W(32), .IMG_H(32)) dut32 (
        .clk(clk), .rst(rst32), .pix_in(pix32), .pix_valid(pv32), .sof(sof32),
        .da(a32), .db(b32), .dc(c32), .dd(d32), .de(e32), .df(f32), .dg(g32), .dh(h32), .di(i32),
        .win_valid(wv32), .frame_done(fd32)
    );

    function automatic logic [9*DW-1:0] obs4();
        return {a4, b4, c4, d4, e4, f4, g4, h4, i4};
    endfunction

    function automatic logic [9*DW-1:0] obs32();
        return {a32, b32, c32, d32, e32, f32, g32, h32, i32};
    endfunction

    // Reference window whose bottom-right pixel is frame index k (4 wide).
    function automatic logic [9*DW-1:0] model4(input int k);
        logic [9*DW-1:0] res = '0;
        int r = k / 4;
        int c = k % 4;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                res = {res[8*DW-1:0], DW'(exp4[(r - 2 + i) * 4 + (c - 2 + j)])};
        return res;
    endfunction

    function automatic logic [9*DW-1:0] model32(input int k);
        logic [9*DW-1:0] res = '0;
        int r = k / 32;
        int c = k % 32;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                res = {res[8*DW-1:0], DW'(img32[(r - 2 + i) * 32 + (c - 2 + j)])};
        return res;
    endfunction

    // One accepted sample; returns at 1 time unit after the accepting edge.
    task automatic drive4(input logic [DW-1:0] p, input logic s);
        pix4 = p; sof4 = s; pv4 = 1'b1;
        @(posedge clk); #1;
        pv4 = 1'b0; sof4 = 1'b0; pix4 = DW'($urandom);
    endtask

    task automatic drive32(input logic [DW-1:0] p, input logic s);
        pix32 = p; sof32 = s; pv32 = 1'b1;
        @(posedge clk); #1;
        pv32 = 1'b0; sof32 = 1'b0; pix32 = DW'($urandom);
    endtask

    task automatic test_reset();
        rst4 = 1'b1; rst32 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks += 4;
        if (obs4() !== '0) begin failures++; $display("FAIL reset_taps4: got %0h expected 0", obs4()); end
        if ({wv4, fd4} !== 2'b00) begin failures++; $display("FAIL reset_flags4: got %b expected 00", {wv4, fd4}); end
        if (obs32() !== '0) begin failures++; $display("FAIL reset_taps32: got %0h expected 0", obs32()); end
        if ({wv32, fd32} !== 2'b00) begin failures++; $display("FAIL reset_flags32: got %b expected 00", {wv32, fd32}); end
        rst4 = 1'b0; rst32 = 1'b0;
        $display("reset: checked outputs cleared");
    endtask

    // Full 4x4 frame from exp4[], with 'gap' idle cycles after each sample.
    task automatic test_frame4(input string name, input int gap, input logic use_sof);
        int wins = 0;
        int fds = 0;
        logic want_v;
        logic [9*DW-1:0] held;
        for (int k = 0; k < 16; k++) begin
            drive4(DW'(exp4[k]), use_sof && (k == 0));
            want_v = (k / 4 >= 2) && (k % 4 >= 2);
            checks += 2;
            if (wv4 !== want_v) begin
                failures++;
                $display("FAIL %s_win_valid k=%0d: got %b expected %b", name, k, wv4, want_v);
            end
            if (fd4 !== (k == 15)) begin
                failures++;
                $display("FAIL %s_frame_done k=%0d: got %b expected %b", name, k, fd4, (k == 15));
            end
            if (fd4) fds++;
            if (want_v) begin
                wins++;
                checks++;
                if (obs4() !== model4(k)) begin
                    failures++;
                    $display("FAIL %s_taps k=%0d: got %0h expected %0h", name, k, obs4(), model4(k));
                end
            end
            held = obs4();
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                checks += 3;
                if (wv4 !== 1'b0) begin failures++; $display("FAIL %s_idle_valid k=%0d: got %b expected 0", name, k, wv4); end
                if (fd4 !== 1'b0) begin failures++; $display("FAIL %s_idle_done k=%0d: got %b expected 0", name, k, fd4); end
                if (obs4() !== held) begin failures++; $display("FAIL %s_idle_hold k=%0d: got %0h expected %0h", name, k, obs4(), held); end
            end
        end
        if (gap == 0) begin
            @(posedge clk); #1;
            checks++;
            if (fd4 !== 1'b0) begin failures++; $display("FAIL %s_done_width: got %b expected 0", name, fd4); end
        end
        checks += 2;
        if (wins !== 4) begin failures++; $display("FAIL %s_window_count: got %0d expected 4", name, wins); end
        if (fds !== 1) begin failures++; $display("FAIL %s_done_count: got %0d expected 1", name, fds); end
        $display("%s: gap=%0d windows=%0d frame_done=%0d", name, gap, wins, fds);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 16; k++) exp4[k] = k;
        test_frame4("b2b_frame1", 0, 1'b1);
        test_frame4("b2b_frame2_nosof", 0, 1'b0);
    endtask

    task automatic test_gaps();
        for (int k = 0; k < 16; k++) exp4[k] = k;
        test_frame4("gaps", 3, 1'b1);
    endtask

    task automatic test_sof_restart();
        for (int k = 0; k < 16; k++) exp4[k] = k;
        for (int k = 0; k < 7; k++) begin
            drive4(DW'(k), (k == 0) || (k == 6));
            checks++;
            if (wv4 !== 1'b0) begin failures++; $display("FAIL sof_restart_partial k=%0d: got %b expected 0", k, wv4); end
        end
        test_frame4("sof_restart_fresh", 0, 1'b1);
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 10; k++) drive4(DW'(k), k == 0);
        rst4 = 1'b1;
        @(posedge clk); #1;
        rst4 = 1'b0;
        checks += 2;
        if (obs4() !== '0) begin failures++; $display("FAIL reset_mid_taps: got %0h expected 0", obs4()); end
        if ({wv4, fd4} !== 2'b00) begin failures++; $display("FAIL reset_mid_flags: got %b expected 00", {wv4, fd4}); end
        for (int k = 10; k < 16; k++) begin
            drive4(DW'(k), 1'b0);
            checks++;
            if ({wv4, fd4} !== 2'b00) begin failures++; $display("FAIL reset_mid_tail k=%0d: got %b expected 00", k, {wv4, fd4}); end
        end
        $display("reset_mid: partial frame discarded");
        for (int k = 0; k < 16; k++) exp4[k] = k;
        test_frame4("reset_mid_recover", 0, 1'b1);
    endtask

    // sof on what would be the last pixel: no frame_done, new frame starts there.
    task automatic test_sof_priority();
        for (int k = 0; k < 15; k++) drive4(DW'(k), k == 0);
        for (int k = 0; k < 16; k++) exp4[k] = (k == 0) ? 15 : k + 100;
        test_frame4("sof_priority", 0, 1'b1);
    endtask

    task automatic test_random32();
        for (int f = 0; f < 2; f++) begin
            int wins = 0;
            int fds = 0;
            logic want_v;
            for (int k = 0; k < 1024; k++) img32[k] = int'($urandom_range(0, (1 << DW) - 1));
            for (int k = 0; k < 1024; k++) begin
                drive32(DW'(img32[k]), (f == 0) && (k == 0));
                want_v = (k / 32 >= 2) && (k % 32 >= 2);
                checks += 2;
                if (wv32 !== want_v) begin failures++; $display("FAIL rand32_valid f=%0d k=%0d: got %b expected %b", f, k, wv32, want_v); end
                if (fd32 !== (k == 1023)) begin failures++; $display("FAIL rand32_done f=%0d k=%0d: got %b expected %b", f, k, fd32, (k == 1023)); end
                if (fd32) fds++;
                if (want_v) begin
                    wins++;
                    checks++;
                    if (obs32() !== model32(k)) begin
                        failures++;
                        $display("FAIL rand32_taps f=%0d k=%0d: got %0h expected %0h", f, k, obs32(), model32(k));
                    end
                end
                if ($urandom_range(0, 3) == 0) begin
                    int gap = int'($urandom_range(1, 2));
                    for (int g = 0; g < gap; g++) begin
                        @(posedge clk); #1;
                        checks++;
                        if ({wv32, fd32} !== 2'b00) begin failures++; $display("FAIL rand32_idle f=%0d k=%0d: got %b expected 00", f, k, {wv32, fd32}); end
                    end
                end
            end
            checks += 2;
            if (wins !== 900) begin failures++; $display("FAIL rand32_window_count f=%0d: got %0d expected 900", f, wins); end
            if (fds !== 1) begin failures++; $display("FAIL rand32_done_count f=%0d: got %0d expected 1", f, fds); end
            $display("rand32 frame %0d: windows=%0d frame_done=%0d", f, wins, fds);
        end
    endtask

    initial begin
        rst4 = 1'b1; pv4 = 1'b0; sof4 = 1'b0; pix4 = '0;
        rst32 = 1'b1; pv32 = 1'b0; sof32 = 1'b0; pix32 = '0;
        @(posedge clk); #1;
        test_reset();
        test_back_to_back();
        test_gaps();
        test_sof_restart();
        test_reset_mid();
        test_sof_priority();
        test_random32();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/win3x3_linebuf.md
WIN3X3_LINEBUF -- requirements
Module: win3x3_linebuf

Interface
REQ-001 SHALL have parameter DW, default 10: pixel data width.
REQ-002 SHALL have parameter IMG_W, default 32: pixels per line, at least 3.
REQ-003 SHALL have parameter IMG_H, default 32: lines per frame, at least 3.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port pix_in, input, DW bits: raster-order pixel sample.
REQ-007 SHALL have port pix_valid, input, 1 bit: pix_in is valid this cycle.
REQ-008 SHALL have port sof, input, 1 bit: start of frame; qualified by pix_valid; marks a sample as col 0, row 0.
REQ-009 SHALL have ports da, db, dc, dd, de, df, dg, dh, di, output, DW bits each, registered: 3x3 window taps, row-major from top-left.
REQ-010 SHALL have port win_valid, output, 1 bit, registered: taps hold a complete window.
REQ-011 SHALL have port frame_done, output, 1 bit, registered: one-cycle pulse after the last pixel of a frame.

Function
REQ-012 SHALL keep a column counter (0..IMG_W-1) and a row counter (0..IMG_H-1) that advance only on accepted samples (pix_valid=1).
REQ-013 SHALL treat an accepted sample with sof=1 as col=0, row=0 regardless of the current counters; the next accepted sample is col=1.
REQ-014 SHALL, on an accepted sample at col=IMG_W-1, wrap col to 0 and increment row.
REQ-015 SHALL, on an accepted sample at col=IMG_W-1 and row=IMG_H-1, return both counters to 0 and assert frame_done on the next cycle for exactly one cycle.
REQ-016 SHALL hold two line buffers, each IMG_W deep (RAM or shift register). They store the previous line and the line before it, and shift only on accepted samples.
REQ-017 SHALL hold a 3x3 register window: each accepted sample shifts the columns left. The new right column is (line-2 tap, line-1 tap, pix_in).
REQ-018 SHALL map taps so that da/db/dc = row r-2, cols c-2/c-1/c; dd/de/df = row r-1, same cols; dg/dh/di = row r, same cols. Here (r,c) is the position of the completing sample.
REQ-019 SHALL assert win_valid one cycle after an accepted sample with row>=2 and col>=2, otherwise deassert it. This gives (IMG_H-2)*(IMG_W-2) windows per frame and no windows that straddle a line edge.
REQ-020 SHALL set latency from the completing accepted sample to win_valid and taps to exactly 1 cycle.
REQ-021 SHALL, when pix_valid=0, hold the counters, line buffers and taps, and drive win_valid=0 on the next cycle.
REQ-022 SHALL, on sof mid-frame, restart the counters. Stale line-buffer data never reaches win_valid=1 because row must reach 2 again, which refills both lines.
REQ-023 SHALL, if pix_valid and sof are high together with counters at the last pixel, give priority to sof: counters go to col 1, row 0, and frame_done is not asserted.
REQ-024 SHALL let taps change only on accepted samples. Their values while win_valid=0 are don't-care.

Reset
REQ-025 SHALL, on rst=1, clear col, row, win_valid, frame_done and all taps to 0 on the next edge. Line-buffer contents need not be cleared.
REQ-026 SHALL give rst priority over pix_valid and sof. A reset mid-frame discards the partial frame, and no window is produced until row reaches 2 and col reaches 2 after the next samples.

Verification
REQ-027 SHALL cover: IMG_W=4, IMG_H=4, pixels 0..15 back-to-back, sof on 0 -> first win_valid 1 cycle after pixel 10 with da..di = 0,1,2,4,5,6,8,9,10.
REQ-028 SHALL cover: same stream -> exactly 4 windows, completing at pixels 10, 11, 14, 15; the last has di=15, da=5. frame_done pulses once, 1 cycle after pixel 15.
REQ-029 SHALL cover: same stream with pix_valid=0 for 3 cycles between every sample -> identical window values and count; win_valid is never high 2 cycles in a row.
REQ-030 SHALL cover: sof reasserted on pixel 6 of the frame, then a fresh 0..15 frame -> no window before the new pixel 10, and that window is 0,1,2,4,5,6,8,9,10.
REQ-031 SHALL cover: rst for 1 cycle after pixel 9 -> all outputs 0 next cycle; feeding pixels 10..15 produces no window.
REQ-032 SHALL cover: IMG_W=32, IMG_H=32 random frame -> every window matches a reference 3x3 extraction, with 900 windows per frame.
